// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default widths for the D-memory arbiter.
// Default widths track the control unit's D_MAR bus so both sides stay in step.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W  = 8;
    localparam int DMEM_DATA_W  = 16;
    localparam int DMEM_MEM_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    // Width of the access-latency down-counter; it only ever holds MEM_LAT-1.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// arb_rr2: two-input grant selector for the D-memory arbiter.
// Default build: round-robin on ties, the side not served last wins.
// With DMEM_ARB_CPU_PRIO_EN defined: requester 0 (CPU) always wins ties and
// last_i is ignored.
module arb_rr2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,   // 1: side 1 was served last, so side 0 wins a tie
    input  logic       accept_i, // arbiter can take a new transfer this cycle
    output logic [1:0] gnt_o     // one-hot, bit n grants requester n
);

    // Resolve the one-hot grant for the current accept opportunity.
    always_comb begin
        gnt_o = 2'b00;
        if (accept_i) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            gnt_o[0] = req0_i;
            gnt_o[1] = req1_i & ~req0_i;
`else
            if (req0_i && req1_i) begin
                gnt_o[0] = last_i;
                gnt_o[1] = ~last_i;
            end else begin
                gnt_o[0] = req0_i;
                gnt_o[1] = req1_i;
            end
`endif
        end
    end

`ifdef DMEM_ARB_CPU_PRIO_EN
    // The pointer is still tracked by the parent but plays no part here.
    logic unused_last;
    assign unused_last = last_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU control
// path (side 0) and a secondary DMA/debug master (side 1). Each granted access
// runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE and ends with a one-cycle done.
// Optional macro DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority on ties
// (handled inside arb_rr2); the default build is round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int MEM_LAT = DMEM_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset_cycle,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               CNT_W    = lat_cnt_w(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              side_q, side_d;
    logic              we_l_q, we_l_d;
    logic [ADDR_W-1:0] addr_l_q, addr_l_d;
    logic [DATA_W-1:0] wdata_l_q, wdata_l_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic [1:0]        sel;
    logic              in_access;

    assign accept = (state_q == ST_IDLE);

    arb_rr2 u_arb (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .accept_i (accept),
        .gnt_o    (sel)
    );

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, count out the access, single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel != 2'b00) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of latched request, counter, pointer and registered outputs.
    always_comb begin
        cnt_d     = cnt_q;
        last_d    = last_q;
        side_d    = side_q;
        we_l_d    = we_l_q;
        addr_l_d  = addr_l_q;
        wdata_l_d = wdata_l_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata_q;
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sel != 2'b00) begin
                    // Snapshot the winner so later request changes cannot leak in.
                    side_d    = sel[1];
                    we_l_d    = sel[1] ? we1 : we0;
                    addr_l_d  = sel[1] ? addr1 : addr0;
                    wdata_l_d = sel[1] ? wdata1 : wdata0;
                    cnt_d     = CNT_LOAD;
                    gnt0_d    = sel[0];
                    gnt1_d    = sel[1];
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_l_q) begin
                        rdata_d = mem_rdata;
                    end
                    done0_d = ~side_q;
                    done1_d = side_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                last_d = side_q;
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
            end
            default: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and latched request; all cleared on reset.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            cnt_q     <= '0;
            last_q    <= 1'b1;
            side_q    <= 1'b0;
            we_l_q    <= 1'b0;
            addr_l_q  <= '0;
            wdata_l_q <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            side_q    <= side_d;
            we_l_q    <= we_l_d;
            addr_l_q  <= addr_l_d;
            wdata_l_q <= wdata_l_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory port decodes from state and latched copy only, never from req.
    always_comb begin
        in_access = (state_q == ST_ACCESS);
        mem_re    = in_access & ~we_l_q;
        mem_we    = in_access & we_l_q;
        mem_addr  = in_access ? addr_l_q : '0;
        mem_wdata = in_access ? wdata_l_q : '0;
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances (MEM_LAT=1 and MEM_LAT=3) checked
// every cycle against a transaction-timeline model, plus directed scenarios.
module tb_dmem_arbiter;

    logic clk;
    logic reset_cycle;

    logic        req_s   [2][2];
    logic        we_s    [2][2];
    logic [7:0]  addr_s  [2][2];
    logic [15:0] wdata_s [2][2];
    logic        gnt_s   [2][2];
    logic        done_s  [2][2];
    logic [15:0] rdata_s     [2];
    logic [7:0]  mem_addr_s  [2];
    logic [15:0] mem_wdata_s [2];
    logic        mem_re_s    [2];
    logic        mem_we_s    [2];
    logic [15:0] mem_rdata_s [2];
    logic        busy_s      [2];

    logic [15:0] simmem [2][256];

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT((l == 0) ? 1 : 3)) u_dut (
            .clk         (clk),
            .reset_cycle (reset_cycle),
            .req0        (req_s[l][0]),
            .we0         (we_s[l][0]),
            .addr0       (addr_s[l][0]),
            .wdata0      (wdata_s[l][0]),
            .req1        (req_s[l][1]),
            .we1         (we_s[l][1]),
            .addr1       (addr_s[l][1]),
            .wdata1      (wdata_s[l][1]),
            .gnt0        (gnt_s[l][0]),
            .gnt1        (gnt_s[l][1]),
            .done0       (done_s[l][0]),
            .done1       (done_s[l][1]),
            .rdata       (rdata_s[l]),
            .mem_addr    (mem_addr_s[l]),
            .mem_wdata   (mem_wdata_s[l]),
            .mem_re      (mem_re_s[l]),
            .mem_we      (mem_we_s[l]),
            .mem_rdata   (mem_rdata_s[l]),
            .busy        (busy_s[l])
        );
        assign mem_rdata_s[l] = simmem[l][mem_addr_s[l]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 8'h12) return 16'hBEEF;
        if (a == 8'h10) return 16'hCAFE;
        return {b, ~b};
    endfunction

    function automatic int lat_of(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] pack_out(input int l);
        return {17'd0, gnt_s[l][0], gnt_s[l][1], done_s[l][0], done_s[l][1], busy_s[l],
                mem_re_s[l], mem_we_s[l], mem_addr_s[l], mem_wdata_s[l], rdata_s[l]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Simulated data memory: writes land on the edge that ends a write cycle.
    initial begin
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 256; a++) simmem[l][a] = init_word(a);
        forever begin
            @(posedge clk);
            for (int l = 0; l < 2; l++)
                if (mem_we_s[l] === 1'b1) simmem[l][mem_addr_s[l]] = mem_wdata_s[l];
        end
    end

    // Reference model: one transaction per lane, described by its accept edge t0.
    // Edges t0..t0+L-1 open access cycles, edge t0+L opens the done cycle,
    // the next accept is possible at edge t0+L+2.
    int          cyc;
    bit          m_valid [2];
    int          m_t0    [2];
    bit          m_side  [2];
    logic        m_we    [2];
    logic [7:0]  m_addr  [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_rdata [2];
    bit          m_last  [2];
    int          m_free  [2];
    logic [15:0] refmem  [2][256];

    initial begin
        int  L;
        bit  r0, r1, w;
        cyc = 0;
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 256; a++) refmem[l][a] = init_word(a);
            m_valid[l] = 0; m_last[l] = 1; m_rdata[l] = 16'h0; m_free[l] = 0;
            m_t0[l] = 0; m_side[l] = 0; m_we[l] = 0; m_addr[l] = 0; m_wdata[l] = 0;
        end
        forever begin
            @(posedge clk or posedge reset_cycle);
            if (reset_cycle) begin
                for (int l = 0; l < 2; l++) begin
                    m_valid[l] = 0; m_last[l] = 1; m_rdata[l] = 16'h0; m_free[l] = 0;
                end
            end else begin
                cyc++;
                for (int l = 0; l < 2; l++) begin
                    L = lat_of(l);
                    if (m_valid[l] && cyc == m_t0[l] + L) begin
                        if (m_we[l]) refmem[l][m_addr[l]] = m_wdata[l];
                        else         m_rdata[l] = refmem[l][m_addr[l]];
                    end
                    if (m_valid[l] && cyc == m_t0[l] + L + 1) begin
                        m_last[l]  = m_side[l];
                        m_valid[l] = 0;
                    end
                    r0 = (req_s[l][0] === 1'b1);
                    r1 = (req_s[l][1] === 1'b1);
                    if (!m_valid[l] && cyc >= m_free[l] && (r0 || r1)) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                        w = r0 ? 1'b0 : 1'b1;
`else
                        if (r0 && r1) w = m_last[l] ? 1'b0 : 1'b1;
                        else          w = r1;
`endif
                        m_side[l]  = w;
                        m_we[l]    = we_s[l][w];
                        m_addr[l]  = addr_s[l][w];
                        m_wdata[l] = wdata_s[l][w];
                        m_t0[l]    = cyc;
                        m_valid[l] = 1;
                        m_free[l]  = cyc + L + 2;
                    end
                end
            end
        end
    end

    // Compare process: every cycle out of reset, both lanes.
    initial begin
        int  L;
        bit  act, acc, dn;
        forever begin
            @(negedge clk);
            if (reset_cycle === 1'b0) begin
                for (int l = 0; l < 2; l++) begin
                    L   = lat_of(l);
                    act = m_valid[l] && cyc >= m_t0[l] && cyc <= m_t0[l] + L;
                    acc = m_valid[l] && cyc >= m_t0[l] && cyc <= m_t0[l] + L - 1;
                    dn  = m_valid[l] && cyc == m_t0[l] + L;
                    chk($sformatf("lane%0d_ctrl", l),
                        {gnt_s[l][0], gnt_s[l][1], done_s[l][0], done_s[l][1], busy_s[l]},
                        {act && !m_side[l], act && m_side[l], dn && !m_side[l], dn && m_side[l], act});
                    chk($sformatf("lane%0d_mem", l),
                        {mem_re_s[l], mem_we_s[l], mem_addr_s[l], mem_wdata_s[l]},
                        {acc && !m_we[l], acc && m_we[l], acc ? m_addr[l] : 8'h0, acc ? m_wdata[l] : 16'h0});
                    chk($sformatf("lane%0d_rdata", l), rdata_s[l], m_rdata[l]);
                end
            end
        end
    end

    task automatic new_fields(input int l, input int s);
        we_s[l][s]    = 1'($urandom_range(1));
        addr_s[l][s]  = 8'($urandom_range(15));
        wdata_s[l][s] = 16'($urandom);
    endtask

    // Random requesters on one lane: hold until done, then drop or re-request.
    task automatic run_random(input int l, input int n);
        logic dn [2];
        logic gn [2];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                dn[s] = done_s[l][s];
                gn[s] = gnt_s[l][s];
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (req_s[l][s]) begin
                    if (dn[s] === 1'b1) begin
                        if ($urandom_range(3) != 0) req_s[l][s] = 1'b0;
                        else new_fields(l, s);
                    end else if (gn[s] === 1'b1 && $urandom_range(1) == 1) begin
                        addr_s[l][s]  = 8'($urandom_range(15));
                        wdata_s[l][s] = 16'($urandom);
                    end
                end else if ($urandom_range(2) == 0) begin
                    req_s[l][s] = 1'b1;
                    new_fields(l, s);
                end
            end
        end
        req_s[l][0] = 1'b0;
        req_s[l][1] = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int side;
        int exp_side;
        bit seen;
        reset_cycle = 1'b1;
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 2; s++) begin
                req_s[l][s] = 1'b0; we_s[l][s] = 1'b0;
                addr_s[l][s] = 8'h0; wdata_s[l][s] = 16'h0;
            end
        repeat (3) tick();
        chk("reset_lane0", pack_out(0), 64'h0);
        chk("reset_lane1", pack_out(1), 64'h0);
        #2 reset_cycle = 1'b0;
        tick();

        // CPU read alone, MEM_LAT=1
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 8'h12;
        tick();
        chk("t1_access", {mem_re_s[0], mem_we_s[0], mem_addr_s[0]}, {1'b1, 1'b0, 8'h12});
        chk("t1_gnt", {gnt_s[0][0], gnt_s[0][1], busy_s[0], done_s[0][0]}, 4'b1010);
        tick();
        chk("t1_done", {done_s[0][0], done_s[0][1], mem_re_s[0], gnt_s[0][1]}, 4'b1000);
        chk("t1_rdata", rdata_s[0], 16'hBEEF);
        req_s[0][0] = 1'b0;
        tick();
        chk("t1_idle", {gnt_s[0][0], gnt_s[0][1], busy_s[0], done_s[0][0]}, 4'b0000);

        // Secondary write alone, MEM_LAT=1
        req_s[0][1] = 1'b1; we_s[0][1] = 1'b1; addr_s[0][1] = 8'h05; wdata_s[0][1] = 16'h1234;
        tick();
        chk("t2_access", {mem_re_s[0], mem_we_s[0], mem_addr_s[0], mem_wdata_s[0]},
            {1'b0, 1'b1, 8'h05, 16'h1234});
        tick();
        chk("t2_done", {done_s[0][0], done_s[0][1], mem_we_s[0]}, 3'b010);
        chk("t2_rdata_kept", rdata_s[0], 16'hBEEF);
        req_s[0][1] = 1'b0;
        tick();

        // Continuous tie on lane 0
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 8'h03;
        req_s[0][1] = 1'b1; we_s[0][1] = 1'b1; addr_s[0][1] = 8'h04; wdata_s[0][1] = 16'h0A0A;
        for (int n = 0; n < 4; n++) begin
            side = -1;
            for (int c = 0; c < 20 && side < 0; c++) begin
                tick();
                if (done_s[0][0] === 1'b1) side = 0;
                else if (done_s[0][1] === 1'b1) side = 1;
            end
`ifdef DMEM_ARB_CPU_PRIO_EN
            exp_side = 0;
`else
            exp_side = n % 2;
`endif
            chk($sformatf("t3_order%0d", n), 64'(side), 64'(exp_side));
        end
        req_s[0][0] = 1'b0; req_s[0][1] = 1'b0;
        repeat (3) tick();

        // MEM_LAT=3 read with address changed after grant
        req_s[1][0] = 1'b1; we_s[1][0] = 1'b0; addr_s[1][0] = 8'h10;
        tick();
        chk("t4_c2", {mem_re_s[1], gnt_s[1][0], mem_addr_s[1]}, {1'b1, 1'b1, 8'h10});
        addr_s[1][0] = 8'h20;
        tick();
        chk("t4_c3", {mem_re_s[1], done_s[1][0], mem_addr_s[1]}, {1'b1, 1'b0, 8'h10});
        tick();
        chk("t4_c4", {mem_re_s[1], done_s[1][0], mem_addr_s[1]}, {1'b1, 1'b0, 8'h10});
        tick();
        chk("t4_c5_done", {mem_re_s[1], done_s[1][0], mem_addr_s[1]}, {1'b0, 1'b1, 8'h00});
        chk("t4_rdata", rdata_s[1], 16'hCAFE);
        req_s[1][0] = 1'b0;
        repeat (2) tick();

        // Reset during a write access on lane 1
        req_s[1][1] = 1'b1; we_s[1][1] = 1'b1; addr_s[1][1] = 8'h07; wdata_s[1][1] = 16'h5A5A;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (mem_we_s[1] === 1'b1) seen = 1;
        end
        chk("t5_we_seen", 64'(seen), 64'd1);
        #2 reset_cycle = 1'b1;
        #1;
        chk("t5_we_drop", 64'(mem_we_s[1]), 64'd0);
        chk("t5_lane1_zero", pack_out(1), 64'h0);
        chk("t5_lane0_zero", pack_out(0), 64'h0);
        req_s[1][1] = 1'b0;
        repeat (2) tick();
        reset_cycle = 1'b0;
        repeat (5) tick();
        chk("t5_after", {busy_s[1], done_s[1][0], done_s[1][1]}, 3'b000);

        run_random(0, 3000);
        run_random(1, 3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
